// File: rtl/rob_entry_allocator.sv
`default_nettype none
// ============================================================================
// Module      : rob_entry_allocator
// Description : Circular ROB index allocator. Hands out WIDTH-entry groups,
//               reclaims in order on commit, collapses on flush.
//               Optional stats ports enabled by ROB_ALLOC_STATS_EN.
// Revision    : 1.0
// ============================================================================
module rob_entry_allocator #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5,
  parameter int WIDTH = 4,
  parameter int CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_ready,
  output logic                   alloc_valid,
  output logic [WIDTH*IDX_W-1:0] rob_entries,
  input  logic [2:0]             commit_count,
  input  logic                   flush,
  output logic [IDX_W-1:0]       head_idx,
  output logic [CNT_W-1:0]       occupancy,
  output logic                   empty,
  output logic                   full,
  output logic                   underflow_err
`ifdef ROB_ALLOC_STATS_EN
  ,
  output logic [15:0]            stall_cycles,
  output logic [CNT_W-1:0]       occ_hwm
`endif
);

  localparam logic [CNT_W:0]   c_depth     = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0]   c_width     = (CNT_W+1)'(WIDTH);
  localparam logic [IDX_W-1:0] c_width_idx = IDX_W'(WIDTH);

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [CNT_W:0]   w_count_ext;
  logic [CNT_W:0]   w_commit_ext;
  logic [CNT_W:0]   w_commit_clip;
  logic [CNT_W:0]   w_c_eff;
  logic [CNT_W:0]   w_free;
  logic [CNT_W:0]   w_count_next;
  logic [IDX_W-1:0] w_head_next;
  logic             w_fire;
  logic             w_err_set;

  // All arithmetic is one bit wider than the counter so DEPTH itself and
  // intermediate sums are representable without wrap.
  assign w_count_ext   = {1'b0, r_count};
  assign w_commit_ext  = (CNT_W+1)'(commit_count);
  assign w_commit_clip = (w_commit_ext > c_width) ? c_width : w_commit_ext;
  assign w_c_eff       = (w_commit_clip > w_count_ext) ? w_count_ext : w_commit_clip;
  assign w_err_set     = (w_commit_ext > w_count_ext) || (w_commit_ext > c_width);
  assign w_free        = c_depth - w_count_ext;

  // Same-cycle commits are deliberately not bypassed into alloc_valid.
  assign alloc_valid   = !flush && (w_free >= c_width);
  assign w_fire        = alloc_valid && alloc_ready;
  assign w_head_next   = IDX_W'(r_head + w_c_eff);
  assign w_count_next  = w_count_ext + (w_fire ? c_width : '0) - w_c_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err  <= r_err | w_err_set;
      r_head <= w_head_next;
      if (flush) begin
        r_tail  <= w_head_next;
        r_count <= '0;
      end else begin
        if (w_fire) begin
          r_tail <= r_tail + c_width_idx;
        end
        r_count <= CNT_W'(w_count_next);
      end
    end
  end

  // Each slot wraps independently so an unaligned group may straddle DEPTH-1 -> 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    assign rob_entries[i*IDX_W +: IDX_W] = r_tail + IDX_W'(i);
  end

  assign head_idx      = r_head;
  assign occupancy     = r_count;
  assign empty         = (r_count == '0);
  assign full          = (r_count == CNT_W'(DEPTH));
  assign underflow_err = r_err;

`ifdef ROB_ALLOC_STATS_EN
  logic [15:0]      r_stall;
  logic [CNT_W-1:0] r_hwm;
  logic [CNT_W-1:0] w_occ_next;
  logic             w_stall;

  assign w_stall    = alloc_ready && !alloc_valid && !flush;
  assign w_occ_next = flush ? '0 : CNT_W'(w_count_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
      r_hwm   <= '0;
    end else begin
      if (w_stall && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
      if (w_occ_next > r_hwm) begin
        r_hwm <= w_occ_next;
      end
    end
  end

  assign stall_cycles = r_stall;
  assign occ_hwm      = r_hwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_entry_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_entry_allocator
// Description : Directed + random bench against a queue-based ROB model.
// Revision    : 1.0
// ============================================================================
module tb_rob_entry_allocator;

  localparam int D = 32;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_ready;
  logic        alloc_valid;
  logic [19:0] rob_entries;
  logic [2:0]  commit_count;
  logic        flush;
  logic [4:0]  head_idx;
  logic [5:0]  occupancy;
  logic        empty;
  logic        full;
  logic        underflow_err;
`ifdef ROB_ALLOC_STATS_EN
  logic [15:0] stall_cycles;
  logic [5:0]  occ_hwm;
`endif

  rob_entry_allocator dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_ready   (alloc_ready),
    .alloc_valid   (alloc_valid),
    .rob_entries   (rob_entries),
    .commit_count  (commit_count),
    .flush         (flush),
    .head_idx      (head_idx),
    .occupancy     (occupancy),
    .empty         (empty),
    .full          (full),
    .underflow_err (underflow_err)
`ifdef ROB_ALLOC_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .occ_hwm       (occ_hwm)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: the live entries themselves, oldest first.
  int q[$];
  int m_tail;
  bit m_err;
  int m_stall;
  int m_hwm;

  function automatic int m_head();
    return (q.size() != 0) ? q[0] : m_tail;
  endfunction

  function automatic logic [31:0] pack(input int s0, input int s1, input int s2, input int s3);
    return 32'(s0 + (s1 << 5) + (s2 << 10) + (s3 << 15));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_hwm   = 0;
  endtask

  task automatic check_all(input string tag);
    bit fl_now;
    int t;
    fl_now = flush;
    t = m_tail;
    check({tag, "_av"}, 32'(alloc_valid), 32'(!fl_now && ((D - q.size()) >= W)));
    check({tag, "_rob"}, 32'(rob_entries), pack(t % D, (t+1) % D, (t+2) % D, (t+3) % D));
    check({tag, "_head"}, 32'(head_idx), 32'(m_head()));
    check({tag, "_occ"}, 32'(occupancy), 32'(q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(q.size() == D));
    check({tag, "_err"}, 32'(underflow_err), 32'(m_err));
`ifdef ROB_ALLOC_STATS_EN
    check({tag, "_stall"}, 32'(stall_cycles), 32'(m_stall));
    check({tag, "_hwm"}, 32'(occ_hwm), 32'(m_hwm));
`endif
  endtask

  task automatic model_step(input bit rdy, input int cc, input bit fl);
    bit av;
    int clip;
    int ceff;
    av   = !fl && ((D - q.size()) >= W);
    clip = (cc > W) ? W : cc;
    ceff = (clip < q.size()) ? clip : q.size();
    if (rdy && !av && !fl && m_stall < 65535) m_stall++;
    if (cc > q.size() || cc > W) m_err = 1'b1;
    repeat (ceff) void'(q.pop_front());
    if (fl) begin
      m_tail = m_head();
      q.delete();
    end else if (av && rdy) begin
      for (int i = 0; i < W; i++) q.push_back((m_tail + i) % D);
      m_tail = (m_tail + W) % D;
    end
    if (q.size() > m_hwm) m_hwm = q.size();
  endtask

  task automatic drive(input bit rdy, input int cc, input bit fl, input string tag);
    alloc_ready  = rdy;
    commit_count = 3'(cc);
    flush        = fl;
    #1;
    check_all(tag);
  endtask

  task automatic tick(input bit rdy, input int cc, input bit fl);
    @(posedge clk);
    model_step(rdy, cc, fl);
    #1;
  endtask

  task automatic do_cycle(input bit rdy, input int cc, input bit fl, input string tag);
    drive(rdy, cc, fl, tag);
    tick(rdy, cc, fl);
  endtask

  task automatic do_reset();
    alloc_ready  = 1'b0;
    commit_count = 3'd0;
    flush        = 1'b0;
    rst          = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alloc_ready = 1'b0;
    commit_count = 3'd0;
    flush = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("rst_rob_const", 32'(rob_entries), pack(0, 1, 2, 3));
    check("rst_av_const", 32'(alloc_valid), 32'd1);

    // Fill the ROB with eight back-to-back groups.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 0, 1'b0, "t1");
      check("t1_group", 32'(rob_entries), pack(4*k, 4*k+1, 4*k+2, 4*k+3));
      tick(1'b1, 0, 1'b0);
    end
    check("t1_full", 32'(full), 32'd1);
    check("t1_av", 32'(alloc_valid), 32'd0);
    check("t1_occ", 32'(occupancy), 32'd32);
    repeat (3) do_cycle(1'b1, 0, 1'b0, "stall");
`ifdef ROB_ALLOC_STATS_EN
    check("stats_stall3", 32'(stall_cycles), 32'd3);
    check("stats_hwm32", 32'(occ_hwm), 32'd32);
`endif

    // Commit from full: no bypass of the freed entries.
    drive(1'b1, 4, 1'b0, "t2");
    check("t2_av_same", 32'(alloc_valid), 32'd0);
    tick(1'b1, 4, 1'b0);
    check("t2_av_next", 32'(alloc_valid), 32'd1);
    check("t2_rob", 32'(rob_entries), pack(0, 1, 2, 3));
    check("t2_head", 32'(head_idx), 32'd4);
    do_cycle(1'b1, 0, 1'b0, "t2b");

    // Alloc and commit in the same cycle.
    do_reset();
    do_cycle(1'b1, 0, 1'b0, "t3a");
    do_cycle(1'b1, 0, 1'b0, "t3b");
    do_cycle(1'b1, 3, 1'b0, "t3c");
    check("t3_occ", 32'(occupancy), 32'd9);
    check("t3_head", 32'(head_idx), 32'd3);
    check("t3_tail", 32'(rob_entries), pack(12, 13, 14, 15));

    // Flush with a same-cycle commit.
    do_reset();
    do_cycle(1'b1, 0, 1'b0, "t4a");
    do_cycle(1'b1, 0, 1'b0, "t4b");
    drive(1'b1, 2, 1'b1, "t4f");
    check("t4_av_flush", 32'(alloc_valid), 32'd0);
    tick(1'b1, 2, 1'b1);
    check("t4_head", 32'(head_idx), 32'd2);
    check("t4_occ", 32'(occupancy), 32'd0);
    check("t4_rob", 32'(rob_entries), pack(2, 3, 4, 5));
    // Unaligned group: keep allocating until the slots straddle 31 -> 0.
    repeat (8) do_cycle(1'b1, 4, 1'b0, "t4w");

    // Underflow: commit 4 with only 2 live.
    do_reset();
    do_cycle(1'b1, 0, 1'b0, "t5a");
    do_cycle(1'b0, 2, 1'b0, "t5b");
    do_cycle(1'b0, 4, 1'b0, "t5c");
    check("t5_occ", 32'(occupancy), 32'd0);
    check("t5_head", 32'(head_idx), 32'd4);
    check("t5_err", 32'(underflow_err), 32'd1);
    do_cycle(1'b0, 1, 1'b0, "t5d");
    check("t5_head_empty", 32'(head_idx), 32'd4);
    repeat (3) do_cycle(1'b1, 0, 1'b0, "t5e");
    check("t5_err_sticky", 32'(underflow_err), 32'd1);

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    repeat (5) do_cycle(1'b1, 0, 1'b0, "t6");
    check("t6_occ20", 32'(occupancy), 32'd20);
    alloc_ready = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_occ", 32'(occupancy), 32'd0);
    check("t6_async_av", 32'(alloc_valid), 32'd1);
    check_all("t6_async");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit rdy;
      bit fl;
      int cc;
      int lim;
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      lim = (q.size() < W) ? q.size() : W;
      if ($urandom_range(0, 39) == 0) cc = $urandom_range(0, 7);
      else cc = $urandom_range(0, lim);
      do_cycle(rdy, cc, fl, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_entry_allocator.md
Name: rob_entry_allocator

Overview:
Circular allocator for reorder-buffer entry indices. Each cycle it supplies the rename/decode stage with a group of WIDTH consecutive ROB indices (the decoder's 20-bit ROB_entries_in bus at default parameters). It reclaims entries in order as the commit stage retires them. It also handles a full pipeline flush.

Parameters:
DEPTH, 32, number of ROB entries; must be a power of two and a multiple of WIDTH
IDX_W, 5, index width, equal to log2(DEPTH)
WIDTH, 4, entries allocated per decode group; also the maximum number retired per cycle
CNT_W, 6, occupancy counter width, equal to log2(DEPTH)+1

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
alloc_ready  input  1  decoder accepts a group this cycle (logical_instrs_valid & logical_instrs_ready)
alloc_valid  output  1  at least WIDTH free entries and no flush this cycle
rob_entries  output  WIDTH*IDX_W  slot i = (tail+i) mod DEPTH; slot 0 in the LSBs
commit_count  input  3  entries retired this cycle, 0..WIDTH
flush  input  1  discard all uncommitted entries
head_idx  output  IDX_W  oldest live entry
occupancy  output  CNT_W  live entry count, 0..DEPTH
empty  output  1  occupancy==0
full  output  1  occupancy==DEPTH
underflow_err  output  1  sticky; commit_count exceeded occupancy

Behaviour:
- State registers: head, tail (IDX_W), count (CNT_W), err (1).
- Reset (asynchronous, on rst high): head=0, tail=0, count=0, err=0.
- Output values out of reset: alloc_valid=1, rob_entries={3,2,1,0}, head_idx=0, occupancy=0, empty=1, full=0, underflow_err=0.
- All outputs are combinational from state and the flush input; there are no output registers.
- alloc_valid = !flush && (DEPTH - count) >= WIDTH.
  - Frees from the same cycle's commit are not bypassed; they become visible the next cycle.
- Alloc fire = alloc_valid && alloc_ready.
  - On fire: tail <= (tail+WIDTH) mod DEPTH, and count grows by WIDTH.
  - When alloc_ready is high and alloc_valid is low, no state change results.
- Effective commit: c_eff = min(commit_count, count).
  - commit_count > count sets err=1; err is cleared only by rst.
  - commit_count > WIDTH is treated as WIDTH and also sets err.
  - head <= (head+c_eff) mod DEPTH.
- Simultaneous alloc and commit: count_next = count + (fire ? WIDTH : 0) - c_eff.
  - Arithmetic is done in CNT_W+1 bits; the result never exceeds DEPTH.
- Flush has the highest priority:
  - head_n = (head+c_eff) mod DEPTH; set head <= head_n, tail <= head_n, count <= 0.
  - Alloc is suppressed (alloc_valid is low in the flush cycle).
  - The commit in the same cycle is still honoured.
- Wrap-around: head and tail wrap naturally mod DEPTH. Groups stay WIDTH-aligned unless a flush lands on an unaligned head.
  - An unaligned group may straddle DEPTH-1 to 0; slot indices wrap individually.
- full implies alloc_valid=0.
- empty with commit_count>0 is an underflow: head does not move and err is set.
- Reset asserted mid-operation clears all state immediately. The occupancy view restarts at 0, and upstream must re-initialise its copy of the ROB.

Optional Feature:
ROB_ALLOC_STATS_EN
- Defined: two extra output ports.
  - stall_cycles [15:0]: saturating count of cycles with alloc_ready=1 && alloc_valid=0, flush cycles excluded.
  - occ_hwm [CNT_W-1:0]: maximum occupancy seen since reset.
  - Both are asynchronously reset to 0.
- Undefined: neither port nor its logic exists; core behaviour is identical.

Test Plan:
- Reset, then alloc_ready=1 for 8 cycles with commit_count=0 → rob_entries {3,2,1,0}, {7,6,5,4}, … {31,30,29,28}; then full=1, alloc_valid=0, occupancy=32.
- From full, commit_count=4 with alloc_ready=1 → alloc_valid stays 0 that cycle; next cycle alloc_valid=1, rob_entries={3,2,1,0}, head_idx=4.
- occupancy=8, head=0, alloc fire together with commit_count=3 → occupancy=9, head_idx=3, tail=12.
- occupancy=8, head=0, flush=1 with commit_count=2 and alloc_ready=1 → alloc_valid=0 in that cycle; next cycle head_idx=2, occupancy=0, rob_entries={5,4,3,2}.
- occupancy=2, commit_count=4 → occupancy=0, head advances by 2, underflow_err=1 and stays 1 until rst.
- rst pulsed asynchronously mid-cycle at occupancy=20 → all state 0 before the next clk edge, alloc_valid=1. With ROB_ALLOC_STATS_EN: after the first test plus 3 extra stalled cycles, stall_cycles=3 and occ_hwm=32.
